// File: rtl/reg_rom_arbiter_if.sv
// Requester-side bus of reg_rom_arbiter: req/gnt address handshake plus valid/ready response.
interface reg_rom_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [1:0]        req_i;
  logic [ADDR_W-1:0] addr0_i;
  logic [ADDR_W-1:0] addr1_i;
  logic [1:0]        gnt_o;
  logic [1:0]        rsp_valid_o;
  logic [DATA_W-1:0] rsp_data_o;
  logic [1:0]        rsp_ready_i;

  modport slave (
    input  req_i, addr0_i, addr1_i, rsp_ready_i,
    output gnt_o, rsp_valid_o, rsp_data_o
  );

  modport master (
    output req_i, addr0_i, addr1_i, rsp_ready_i,
    input  gnt_o, rsp_valid_o, rsp_data_o
  );
endinterface

// File: rtl/reg_rom_arbiter.sv
// Two-requester arbiter in front of the combinational reg_rom read port (IDLE->READ->RESP).
// Define REG_ROM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module reg_rom_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_rom_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_q_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_e;

  state_e            state_q;
  logic              owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        vld_q;
  logic              busy_q;
  logic              win_d;
  logic [1:0]        gnt_d;
`ifndef REG_ROM_ARB_FIXED_PRIO_EN
  logic              last_q;
`endif

  always_comb begin
    win_d = 1'b0;
    case (bus.req_i)
      2'b10:   win_d = 1'b1;
`ifdef REG_ROM_ARB_FIXED_PRIO_EN
      2'b11:   win_d = 1'b0;
`else
      2'b11:   win_d = ~last_q;
`endif
      default: win_d = 1'b0;
    endcase
    // Grant is combinational but suppressed while reset is asserted.
    gnt_d = 2'b00;
    if (state_q == IDLE && rst_n && (bus.req_i != 2'b00))
      gnt_d[win_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      vld_q   <= 2'b00;
      busy_q  <= 1'b0;
`ifndef REG_ROM_ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_i != 2'b00) begin
            owner_q <= win_d;
            addr_q  <= win_d ? bus.addr1_i : bus.addr0_i;
            busy_q  <= 1'b1;
            state_q <= READ;
          end
        end
        READ: begin
          data_q  <= rom_q_i;
          vld_q   <= owner_q ? 2'b10 : 2'b01;
          state_q <= RESP;
        end
        RESP: begin
          // addr_q doubles as rom_addr_o, so clearing it returns the ROM port to 0 in IDLE.
          if (bus.rsp_ready_i[owner_q]) begin
`ifndef REG_ROM_ARB_FIXED_PRIO_EN
            last_q  <= owner_q;
`endif
            vld_q   <= 2'b00;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt_o       = gnt_d;
  assign bus.rsp_valid_o = vld_q;
  assign bus.rsp_data_o  = data_q;
  assign rom_addr_o      = addr_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_reg_rom_arbiter.sv
// Scoreboard bench for reg_rom_arbiter: a predictor pushes expected responses at each grant,
// a separate monitor pops and compares them whenever rsp_valid_o is presented.
module tb_reg_rom_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q;
  logic          busy;
  logic [DW-1:0] rom_mem [32];
  int            cyc = 0;

  reg_rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  reg_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .rom_addr_o (rom_addr),
    .rom_q_i    (rom_q),
    .busy_o     (busy)
  );

  assign rom_q = rom_mem[rom_addr];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          w;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    int            gcyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: the arbiter is free between transactions; a transaction spans grant..handshake.
  bit            free = 1'b1;
  bit            last = 1'b1;
  bit            hs_seen = 1'b0;
  bit            first_rsp = 1'b1;
  logic [AW-1:0] cur_addr = '0;
  logic          cur_w = 1'b0;
  int            cur_gcyc = 0;

  // Monitor: compares every presented response against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) first_rsp = 1'b1;
    else if (bus.rsp_valid_o != 2'b00) begin
      chk("rsp_onehot", 64'($onehot(bus.rsp_valid_o)), 64'd1);
      if (exp_q.size() == 0) chk("unexpected_rsp", 64'(bus.rsp_valid_o), 64'd0);
      else begin
        chk("rsp_owner", 64'(bus.rsp_valid_o), exp_q[0].w ? 64'd2 : 64'd1);
        chk("rsp_data", 64'(bus.rsp_data_o), 64'(exp_q[0].data));
        if (first_rsp) chk("rsp_latency", 64'(cyc - exp_q[0].gcyc), 64'd2);
        first_rsp = 1'b0;
        if (bus.rsp_ready_i[exp_q[0].w]) begin
          void'(exp_q.pop_front());
          first_rsp = 1'b1;
          hs_seen   = 1'b1;
        end
      end
    end
  end

  // Predictor: decides the winner from the arbitration rules and pushes the expected response.
  always @(negedge clk) begin
    logic          w;
    logic [AW-1:0] a;
    #1;
    if (!rst_n) begin
      free = 1'b1; last = 1'b1; hs_seen = 1'b0;
      exp_q.delete();
    end else if (free) begin
      chk("busy_idle", 64'(busy), 64'd0);
      chk("romaddr_idle", 64'(rom_addr), 64'd0);
      if (bus.req_i != 2'b00) begin
        if (bus.req_i == 2'b01) w = 1'b0;
        else if (bus.req_i == 2'b10) w = 1'b1;
`ifdef REG_ROM_ARB_FIXED_PRIO_EN
        else w = 1'b0;
`else
        else w = (last == 1'b1) ? 1'b0 : 1'b1;
`endif
        chk("gnt", 64'(bus.gnt_o), w ? 64'd2 : 64'd1);
        a = w ? bus.addr1_i : bus.addr0_i;
        exp_q.push_back('{w: w, data: rom_mem[a], addr: a, gcyc: cyc});
        cur_addr = a; cur_w = w; cur_gcyc = cyc;
        last = w; free = 1'b0;
      end else chk("gnt_none", 64'(bus.gnt_o), 64'd0);
    end else begin
      chk("gnt_busy", 64'(bus.gnt_o), 64'd0);
      chk("busy", 64'(busy), 64'd1);
      chk("romaddr_hold", 64'(rom_addr), 64'(cur_addr));
      if (cyc == cur_gcyc + 1) chk("valid_in_read", 64'(bus.rsp_valid_o), 64'd0);
      if (cyc == cur_gcyc + 2) chk("valid_at_n2", 64'(bus.rsp_valid_o), cur_w ? 64'd2 : 64'd1);
      if (hs_seen) begin free = 1'b1; hs_seen = 1'b0; end
    end
  end

  // One cycle of stimulus: g reports which held requests were accepted this cycle.
  task automatic step(output logic [1:0] g);
    @(negedge clk); #2;
    g = bus.req_i & bus.gnt_o;
    @(posedge clk); #1;
  endtask

  task automatic rand_phase(input int n);
    logic [1:0] g;
    bit pend [2];
    pend[0] = 1'b0; pend[1] = 1'b0;
    bus.req_i = 2'b00;
    for (int c = 0; c < n; c++) begin
      step(g);
      for (int i = 0; i < 2; i++) begin
        if (g[i]) begin
          pend[i] = 1'b0;
          if (i == 0) bus.addr0_i = AW'($urandom); else bus.addr1_i = AW'($urandom);
        end
        if (pend[i] && $urandom_range(0, 19) == 0) pend[i] = 1'b0;
        else if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          if (i == 0) bus.addr0_i = AW'($urandom); else bus.addr1_i = AW'($urandom);
        end
        bus.req_i[i]       = pend[i];
        bus.rsp_ready_i[i] = ($urandom_range(0, 3) != 0);
      end
    end
    bus.req_i = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] g;
    int  k;
    bit  found;
    for (int i = 0; i < 32; i++) rom_mem[i] = $urandom;
    bus.req_i = 2'b00; bus.addr0_i = '0; bus.addr1_i = '0; bus.rsp_ready_i = 2'b00;

    #12;
    chk("rst_gnt", 64'(bus.gnt_o), 64'd0);
    chk("rst_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("rst_data", 64'(bus.rsp_data_o), 64'd0);
    chk("rst_romaddr", 64'(rom_addr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #3 rst_n = 1'b1;

    // Both requesters held: grants alternate starting with 0.
    bus.req_i = 2'b11; bus.addr0_i = 5'd3; bus.addr1_i = 5'd7; bus.rsp_ready_i = 2'b11;
    repeat (24) step(g);
    bus.req_i = 2'b00;
    repeat (4) step(g);

    // Single request, zero-wait ready.
    bus.req_i = 2'b01; bus.addr0_i = 5'd5;
    found = 1'b0;
    for (int c = 0; c < 5 && !found; c++) begin step(g); found = g[0]; end
    chk("t1_granted", 64'(found), 64'd1);
    bus.req_i = 2'b00;
    repeat (4) step(g);

    // Owner 1 stalls the response while requester 0 waits and toggles its ready.
    bus.req_i = 2'b10; bus.addr1_i = 5'd9; bus.rsp_ready_i = 2'b00;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin step(g); found = g[1]; end
    chk("t3_granted", 64'(found), 64'd1);
    bus.req_i = 2'b01; bus.addr0_i = 5'd4; bus.addr1_i = 5'd21;
    for (int c = 0; c < 6; c++) begin
      bus.rsp_ready_i = {1'b0, c[0]};
      step(g);
      chk("t3_no_gnt", 64'(g), 64'd0);
    end
    bus.rsp_ready_i = 2'b11;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin step(g); found = g[0]; end
    chk("t3_next_gnt", 64'(found), 64'd1);
    bus.req_i = 2'b00;
    repeat (4) step(g);

    // Address sweep; the address moves on right after each grant.
    k = 0; bus.addr0_i = '0; bus.req_i = 2'b01; bus.rsp_ready_i = 2'b11;
    for (int c = 0; c < 200 && k < 32; c++) begin
      step(g);
      if (g[0]) begin k++; bus.addr0_i = AW'(k); end
    end
    chk("sweep_count", 64'(k), 64'd32);
    bus.req_i = 2'b00;
    repeat (4) step(g);

    rand_phase(400);
    bus.rsp_ready_i = 2'b11;
    repeat (6) step(g);

    // Asynchronous reset while a read is in flight.
    bus.req_i = 2'b01; bus.addr0_i = AW'($urandom);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk); #2;
      found = (busy === 1'b1) && (bus.rsp_valid_o == 2'b00);
    end
    chk("t5_reach_read", 64'(found), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_gnt", 64'(bus.gnt_o), 64'd0);
    chk("t5_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("t5_data", 64'(bus.rsp_data_o), 64'd0);
    chk("t5_romaddr", 64'(rom_addr), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    bus.req_i = 2'b00;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (2) step(g);
    bus.req_i = 2'b10; bus.addr1_i = AW'($urandom);
    found = 1'b0;
    for (int c = 0; c < 5 && !found; c++) begin step(g); found = g[1]; end
    chk("t5_gnt1", 64'(found), 64'd1);
    bus.req_i = 2'b00;
    repeat (4) step(g);

    rand_phase(300);
    bus.rsp_ready_i = 2'b11;
    repeat (10) step(g);
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
